// File: rtl/avg_window_sched_if.sv
// rtl/avg_window_sched_if.sv - request/sample/result bundle for avg_window_sched
// master drives requests, samples and result-ready; slave is the scheduler.
interface avg_window_sched_if #(
   parameter int NUM_CH        = 4,
   parameter int DATA_IN_WIDTH = 12
);
   logic [NUM_CH-1:0]               i_req;
   logic [NUM_CH-1:0]               i_valid;
   logic [NUM_CH*DATA_IN_WIDTH-1:0] data_in;
   logic [NUM_CH-1:0]               o_ready;
   logic [DATA_IN_WIDTH-1:0]        o_average;
   logic [$clog2(NUM_CH)-1:0]       o_ch;
   logic                            o_avg_valid;
   logic                            i_avg_ready;
   logic                            o_abort;

   modport master (
      output i_req, i_valid, data_in, i_avg_ready,
      input  o_ready, o_average, o_ch, o_avg_valid, o_abort
   );

   modport slave (
      input  i_req, i_valid, data_in, i_avg_ready,
      output o_ready, o_average, o_ch, o_avg_valid, o_abort
   );
endinterface

// File: rtl/avg_window_sched.sv
// rtl/avg_window_sched.sv - round-robin shared block-averaging accumulator
// Optional idle-sample timeout per window when AVG_TIMEOUT_EN is defined.
module avg_window_sched #(
   parameter int NUM_CH         = 4,
   parameter int DATA_IN_WIDTH  = 12,
   parameter int SAMPLING_RATE  = 512,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   avg_window_sched_if.slave    bus
);
   localparam int CHW = $clog2(NUM_CH);
   localparam int SRW = $clog2(SAMPLING_RATE);
   localparam int AW  = DATA_IN_WIDTH + SRW;

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t                   state_q;
   logic [CHW-1:0]           ptr_q;
   logic [CHW-1:0]           grant_q;
   logic [AW-1:0]            acc_q;
   logic [SRW-1:0]           cnt_q;
   logic [NUM_CH-1:0]        ready_q;
   logic [DATA_IN_WIDTH-1:0] avg_q;
   logic [CHW-1:0]           ch_q;
   logic                     avg_valid_q;
   logic                     abort_q;
`ifdef AVG_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [TW-1:0]            tmo_q;
`endif

   logic [CHW-1:0]           grant_d;
   logic                     any_req;
   logic [DATA_IN_WIDTH-1:0] sample;
   logic [AW-1:0]            sum_d;
   logic                     accept;

   // First requester strictly after the pointer, wrapping; NUM_CH need not be a power of two.
   always_comb begin
      grant_d = ptr_q;
      any_req = 1'b0;
      for (int i = 1; i <= NUM_CH; i++) begin
         if (!any_req && bus.i_req[(int'(ptr_q) + i) % NUM_CH]) begin
            any_req = 1'b1;
            grant_d = CHW'((int'(ptr_q) + i) % NUM_CH);
         end
      end
   end

   assign sample = bus.data_in[grant_q*DATA_IN_WIDTH +: DATA_IN_WIDTH];
   assign sum_d  = acc_q + AW'(sample);
   assign accept = (state_q == ACCUM) && bus.i_valid[grant_q];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= CHW'(NUM_CH - 1);
         grant_q     <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         ready_q     <= '0;
         avg_q       <= '0;
         ch_q        <= '0;
         avg_valid_q <= 1'b0;
         abort_q     <= 1'b0;
`ifdef AVG_TIMEOUT_EN
         tmo_q       <= '0;
`endif
      end else begin
         abort_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  ptr_q   <= grant_d;
                  grant_q <= grant_d;
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  ready_q <= NUM_CH'(1) << grant_d;
                  state_q <= ACCUM;
`ifdef AVG_TIMEOUT_EN
                  tmo_q   <= '0;
`endif
               end
            end
            ACCUM: begin
               if (accept) begin
`ifdef AVG_TIMEOUT_EN
                  tmo_q <= '0;
`endif
                  if (cnt_q == SRW'(SAMPLING_RATE - 1)) begin
                     avg_q       <= sum_d[AW-1:SRW];
                     ch_q        <= grant_q;
                     avg_valid_q <= 1'b1;
                     ready_q     <= '0;
                     state_q     <= DONE;
                  end else begin
                     acc_q <= sum_d;
                     cnt_q <= cnt_q + SRW'(1);
                  end
               end else if (!bus.i_req[grant_q]) begin
                  abort_q <= 1'b1;
                  ready_q <= '0;
                  state_q <= IDLE;
`ifdef AVG_TIMEOUT_EN
               end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                  abort_q <= 1'b1;
                  ready_q <= '0;
                  state_q <= IDLE;
               end else begin
                  tmo_q <= tmo_q + TW'(1);
`endif
               end
            end
            DONE: begin
               if (bus.i_avg_ready) begin
                  avg_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.o_ready     = ready_q;
   assign bus.o_average   = avg_q;
   assign bus.o_ch        = ch_q;
   assign bus.o_avg_valid = avg_valid_q;
   assign bus.o_abort     = abort_q;
endmodule

// File: tb/tb_avg_window_sched.sv
// tb/tb_avg_window_sched.sv - directed self-checking bench for avg_window_sched
// Honours AVG_TIMEOUT_EN for the idle-timeout case.
module tb_avg_window_sched;
   localparam int NUM_CH = 4;
   localparam int DW     = 12;
   localparam int SR     = 4;
   localparam int TO     = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   avg_window_sched_if #(.NUM_CH(NUM_CH), .DATA_IN_WIDTH(DW)) bus ();

   avg_window_sched #(
      .NUM_CH(NUM_CH), .DATA_IN_WIDTH(DW),
      .SAMPLING_RATE(SR), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ready"}, 32'(bus.o_ready), 0);
      check({tag, "_avg"},   32'(bus.o_average), 0);
      check({tag, "_ch"},    32'(bus.o_ch), 0);
      check({tag, "_valid"}, 32'(bus.o_avg_valid), 0);
      check({tag, "_abort"}, 32'(bus.o_abort), 0);
   endtask

   // One window on channel ch; request dropped together with the final sample.
   task automatic window(input int ch, input int a, input int b, input int c, input int d,
                         input int exp_avg, input int stall);
      int s[4];
      s[0] = a; s[1] = b; s[2] = c; s[3] = d;
      bus.i_req   = 4'(1 << ch);
      bus.i_valid = '0;
      tick();
      check("grant", 32'(bus.o_ready), 32'(1 << ch));
      for (int k = 0; k < 4; k++) begin
         bus.data_in[ch*DW +: DW] = DW'(s[k]);
         bus.i_valid = 4'(1 << ch);
         if (k == 3) bus.i_req = '0;
         tick();
         if (k == 2) check("early_valid", 32'(bus.o_avg_valid), 0);
      end
      bus.i_valid = '0;
      check("res_valid", 32'(bus.o_avg_valid), 1);
      check("res_avg",   32'(bus.o_average), 32'(exp_avg));
      check("res_ch",    32'(bus.o_ch), 32'(ch));
      check("res_ready", 32'(bus.o_ready), 0);
      for (int k = 0; k < stall; k++) begin
         bus.i_req = '1;
         tick();
         check("stall_valid", 32'(bus.o_avg_valid), 1);
         check("stall_avg",   32'(bus.o_average), 32'(exp_avg));
         check("stall_ch",    32'(bus.o_ch), 32'(ch));
         check("stall_ready", 32'(bus.o_ready), 0);
      end
      bus.i_req       = '0;
      bus.i_avg_ready = 1'b1;
      tick();
      bus.i_avg_ready = 1'b0;
      check("exit_valid", 32'(bus.o_avg_valid), 0);
      check("exit_ready", 32'(bus.o_ready), 0);
   endtask

   initial begin
      int nres;
      int last;
      bus.i_req       = '0;
      bus.i_valid     = '0;
      bus.data_in     = '0;
      bus.i_avg_ready = 1'b0;
      tick();
      check_zero("reset");
      rst = 1'b0;

      window(1, 10, 20, 30, 40, 25, 5);

      // Round robin, all requesting, zero stall.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < NUM_CH; k++) bus.data_in[k*DW +: DW] = DW'(100 * (k + 1));
      bus.i_req       = '1;
      bus.i_valid     = '1;
      bus.i_avg_ready = 1'b1;
      nres = 0;
      last = 0;
      for (int c = 1; c <= 30; c++) begin
         tick();
         if (bus.o_avg_valid) begin
            check("rr_ch",  32'(bus.o_ch), 32'(nres % 4));
            check("rr_avg", 32'(bus.o_average), 32'(100 * (nres % 4 + 1)));
            if (nres > 0) check("rr_period", 32'(c - last), 6);
            else          check("rr_first", 32'(c), 5);
            last = c;
            nres++;
         end
      end
      check("rr_count", 32'(nres), 5);
      bus.i_req       = '0;
      bus.i_valid     = '0;
      bus.i_avg_ready = 1'b0;

      window(2, 4095, 4095, 4095, 4095, 4095, 0);
      window(3, 1, 1, 1, 2, 1, 0);

      // Abort on request drop; pointer then favours channel 3.
      bus.i_req = 4'b0100;
      tick();
      check("ab_grant", 32'(bus.o_ready), 4);
      bus.data_in[2*DW +: DW] = 12'd7;
      bus.i_valid = 4'b0100;
      tick();
      tick();
      bus.i_valid = '0;
      bus.i_req   = 4'b1000;
      tick();
      check("ab_pulse", 32'(bus.o_abort), 1);
      check("ab_ready", 32'(bus.o_ready), 0);
      check("ab_valid", 32'(bus.o_avg_valid), 0);
      tick();
      check("ab_once",  32'(bus.o_abort), 0);
      check("ab_next",  32'(bus.o_ready), 8);

      // Asynchronous reset in the middle of a window.
      bus.data_in[3*DW +: DW] = 12'd50;
      bus.i_valid = 4'b1000;
      tick();
      check("mid_ready", 32'(bus.o_ready), 8);
      #2;
      rst = 1'b1;
      #1;
      check_zero("async_rst");
      rst = 1'b0;
      bus.i_valid = '0;
      bus.i_req   = '0;
      tick();

      // Stalled grant: timeout build aborts, default build waits.
      bus.i_req = 4'b0001;
      tick();
      check("to_grant", 32'(bus.o_ready), 1);
      repeat (TO) tick();
`ifdef AVG_TIMEOUT_EN
      check("to_abort", 32'(bus.o_abort), 1);
      check("to_ready", 32'(bus.o_ready), 0);
      bus.i_req = '0;
      tick();
      check("to_once", 32'(bus.o_abort), 0);
`else
      check("to_noabort", 32'(bus.o_abort), 0);
      check("to_hold",    32'(bus.o_ready), 1);
      bus.i_req = '0;
      tick();
      check("to_dropabort", 32'(bus.o_abort), 1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/avg_window_sched.md
# avg_window_sched

Round-robin scheduler sharing one block-averaging accumulator among NUM_CH sample channels. Grants one requesting channel at a time, accumulates exactly SAMPLING_RATE of its samples, and presents the truncated mean with the channel id on a valid/ready output. Sits between the per-channel ADC capture front-ends and the downstream averaged-data consumer.

## Interface
- NUM_CH, 4: number of requesting channels, 2..16.
- DATA_IN_WIDTH, 12: sample width, unsigned.
- SAMPLING_RATE, 512: samples per window; power of two, >= 2.
- TIMEOUT_CYCLES, 1024: idle-sample limit per window; used only with AVG_TIMEOUT_EN.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  NUM_CH  per-channel request for a window.
- i_valid  in  NUM_CH  per-channel sample valid.
- data_in  in  NUM_CH*DATA_IN_WIDTH  samples; channel k at bits [k*DATA_IN_WIDTH +: DATA_IN_WIDTH].
- o_ready  out  NUM_CH  one-hot accept for the granted channel; zero otherwise.
- o_average  out  DATA_IN_WIDTH  window mean.
- o_ch  out  $clog2(NUM_CH)  channel of o_average.
- o_avg_valid  out  1  result valid; held until accepted.
- i_avg_ready  in  1  consumer accepts result.
- o_abort  out  1  one-cycle pulse: window abandoned.

## Operation
- States: IDLE, ACCUM, DONE. Reset: IDLE, o_ready=0, o_average=0, o_ch=0, o_avg_valid=0, o_abort=0, accumulator=0, sample count=0, round-robin pointer=NUM_CH-1 (channel 0 wins first).
- IDLE: if any i_req bit set, grant first requesting channel after the pointer (wrapping); pointer := granted; clear accumulator and count; go ACCUM. No request: stay.
- ACCUM: o_ready = one-hot of grant. Sample accepted when i_valid[g] & o_ready[g]; acc += data_in[g], count += 1. Other channels' i_valid ignored.
- Accumulator width DATA_IN_WIDTH+$clog2(SAMPLING_RATE); cannot overflow.
- On the SAMPLING_RATE-th accepted sample: o_average := (acc + sample) >> $clog2(SAMPLING_RATE) (truncation), o_ch := g, o_avg_valid := 1, go DONE.
- ACCUM with i_req[g]=0 and no accept that cycle: abort — o_abort pulses, no result, go IDLE. i_req drop coinciding with the final sample: window completes normally.
- DONE: o_ready=0; o_average/o_ch stable; on i_avg_ready go IDLE, o_avg_valid := 0.
- Grant is not re-evaluated until IDLE; requests arriving mid-window wait.

## Timing
- Grant: request seen in IDLE -> o_ready high next cycle.
- Result: o_avg_valid high the cycle after the final accepted sample.
- Back-to-back, zero stall: IDLE 1 + SAMPLING_RATE + DONE 1 cycles per window (i_avg_ready held high).
- o_abort asserted exactly one cycle, in the cycle state returns to IDLE.
- Reset mid-window or mid-DONE: all outputs to reset values immediately; partial window discarded.

## Configuration
- AVG_TIMEOUT_EN defined: ACCUM counts consecutive cycles without an accepted sample; reaching TIMEOUT_CYCLES aborts (o_abort pulse, go IDLE, pointer kept so next channel is favoured). Counter clears on each accept.
- Undefined: no timeout logic; a granted channel may stall ACCUM indefinitely; TIMEOUT_CYCLES unused.

## Test plan
(NUM_CH=4, DATA_IN_WIDTH=12, SAMPLING_RATE=4.)
- Only i_req[1]; samples 10,20,30,40 -> o_ready=4'b0010 one cycle after request; o_average=25, o_ch=1, o_avg_valid the cycle after 40.
- All i_req held, i_avg_ready=1 -> grants in order 0,1,2,3,0; each window exactly 6 cycles.
- Four samples of 4095 -> o_average=4095; samples 1,1,1,2 -> o_average=1 (truncation).
- i_req[2] dropped after 2 samples -> o_abort one pulse, no o_avg_valid, next grant goes to channel 3 if requesting.
- i_avg_ready low 5 cycles in DONE -> o_average/o_ch/o_avg_valid stable, o_ready=0, no new grant; accept -> IDLE next cycle.
- With AVG_TIMEOUT_EN, TIMEOUT_CYCLES=8: grant ch0, no i_valid 8 cycles -> o_abort; without the macro, stays in ACCUM. rst pulse mid-ACCUM -> all outputs 0 immediately.
